batch_controller: RTL and testbench

BATCH_CONTROLLER -- requirements
Module: batch_controller

---
 rtl/batch_controller.sv | 156 +++++++++++++++
 tb/tb_batch_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/batch_controller.sv
// batch_controller: groups accepted transactions into batches. A batch closes
// when full, on a flush request, or after a timeout. The closed batch is then
// offered to the executor, and the conflict checker is told when it completes.
module batch_controller #(
  parameter int unsigned MAX_BATCH_SIZE = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        txn_accept,
  input  logic [63:0] txn_programID,
  input  logic        flush_req,
  output logic        accept_enable,
  output logic        batch_valid,
  input  logic        batch_ready,
  output logic [7:0]  batch_size,
  output logic [31:0] batch_id,
  output logic [63:0] batch_first_pid,
  output logic [1:0]  batch_reason,
  output logic        batch_completed,
  output logic [31:0] stat_batches,
  output logic [31:0] stat_timeouts,
  output logic [31:0] stat_dropped,
  output logic [1:0]  state_o
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned SW = 32;

  localparam logic [1:0] RSN_FULL    = 2'b01;
  localparam logic [1:0] RSN_FLUSH   = 2'b10;
  localparam logic [1:0] RSN_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPATCH = 2'd2,
    S_CLEAR    = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic            r_batch_valid;
  logic [CW-1:0]   r_batch_size;
  logic [SW-1:0]   r_batch_id;
  logic [63:0]     r_batch_first_pid;
  logic [1:0]      r_batch_reason;
  logic            r_batch_completed;
  logic [SW-1:0]   r_stat_batches;
  logic [SW-1:0]   r_stat_timeouts;
  logic [SW-1:0]   r_stat_dropped;

  logic            w_accept_en;
  logic            w_take;
  logic            w_drop;
  logic [CW-1:0]   w_count_next;
  logic            w_full;
  logic            w_timeout;
  logic            w_close;
  logic [1:0]      w_reason;

  // Acceptance gating and batch close decision for the current cycle
  always_comb begin
    w_accept_en  = (r_state == S_IDLE) ||
                   ((r_state == S_COLLECT) && (r_count < CW'(MAX_BATCH_SIZE)));
    w_take       = txn_accept && w_accept_en;
    w_drop       = txn_accept && !w_accept_en;
    w_count_next = r_count + CW'(w_take);
    w_full       = (w_count_next == CW'(MAX_BATCH_SIZE));
    w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    w_close      = w_full || flush_req || w_timeout;
    if (w_full)         w_reason = RSN_FULL;
    else if (flush_req) w_reason = RSN_FLUSH;
    else                w_reason = RSN_TIMEOUT;
  end

  // Batch FSM with registered batch descriptor and dispatch statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_count           <= '0;
      r_timer           <= '0;
      r_batch_valid     <= 1'b0;
      r_batch_size      <= '0;
      r_batch_id        <= '0;
      r_batch_first_pid <= '0;
      r_batch_reason    <= '0;
      r_batch_completed <= 1'b0;
      r_stat_batches    <= '0;
      r_stat_timeouts   <= '0;
    end else begin
      r_batch_completed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (txn_accept) begin
            r_count           <= CW'(1);
            r_timer           <= '0;
            r_batch_first_pid <= txn_programID;
            r_state           <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + TW'(1);
          r_count <= w_count_next;
          if (w_close) begin
            r_state        <= S_DISPATCH;
            r_batch_valid  <= 1'b1;
            r_batch_size   <= w_count_next;
            r_batch_reason <= w_reason;
            if ((w_reason == RSN_TIMEOUT) && (r_stat_timeouts != '1))
              r_stat_timeouts <= r_stat_timeouts + SW'(1);
          end
        end
        S_DISPATCH: begin
          if (batch_ready) begin
            r_batch_valid     <= 1'b0;
            r_batch_completed <= 1'b1;
            r_state           <= S_CLEAR;
            if (r_stat_batches != '1)
              r_stat_batches <= r_stat_batches + SW'(1);
          end
        end
        S_CLEAR: begin
          r_count    <= '0;
          r_timer    <= '0;
          r_batch_id <= r_batch_id + SW'(1);
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Count transactions arriving while acceptance is closed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stat_dropped <= '0;
    else if (w_drop && (r_stat_dropped != '1))
      r_stat_dropped <= r_stat_dropped + SW'(1);
  end

  assign accept_enable   = w_accept_en;
  assign batch_valid     = r_batch_valid;
  assign batch_size      = r_batch_size;
  assign batch_id        = r_batch_id;
  assign batch_first_pid = r_batch_first_pid;
  assign batch_reason    = r_batch_reason;
  assign batch_completed = r_batch_completed;
  assign stat_batches    = r_stat_batches;
  assign stat_timeouts   = r_stat_timeouts;
  assign stat_dropped    = r_stat_dropped;
  assign state_o         = r_state;

endmodule

// File: tb/tb_batch_controller.sv
// Randomized bench for batch_controller with a transaction-level reference
// model; expected batches go to a scoreboard that a monitor drains.
module tb_batch_controller;

  localparam int MAXB = 4;
  localparam int TMO  = 8;
  localparam int NCYC = 3000;

  logic        clk;
  logic        rst_n;
  logic        txn_accept;
  logic [63:0] txn_programID;
  logic        flush_req;
  logic        accept_enable;
  logic        batch_valid;
  logic        batch_ready;
  logic [7:0]  batch_size;
  logic [31:0] batch_id;
  logic [63:0] batch_first_pid;
  logic [1:0]  batch_reason;
  logic        batch_completed;
  logic [31:0] stat_batches;
  logic [31:0] stat_timeouts;
  logic [31:0] stat_dropped;
  logic [1:0]  state_o;

  batch_controller #(.MAX_BATCH_SIZE(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .txn_accept(txn_accept),
    .txn_programID(txn_programID), .flush_req(flush_req),
    .accept_enable(accept_enable), .batch_valid(batch_valid),
    .batch_ready(batch_ready), .batch_size(batch_size), .batch_id(batch_id),
    .batch_first_pid(batch_first_pid), .batch_reason(batch_reason),
    .batch_completed(batch_completed), .stat_batches(stat_batches),
    .stat_timeouts(stat_timeouts), .stat_dropped(stat_dropped),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  size;
    logic [31:0] id;
    logic [63:0] pid;
    logic [1:0]  reason;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: open batch as a list of programIDs plus an age counter
  logic [63:0] m_pend[$];
  int          m_age;
  bit          m_offer;
  bit          m_clear;
  bit          m_bc;
  logic [31:0] m_id;
  logic [31:0] m_batches;
  logic [31:0] m_timeouts;
  logic [31:0] m_dropped;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_pend.delete();
    sb.delete();
    m_age = 0; m_offer = 0; m_clear = 0; m_bc = 0;
    m_id = 0; m_batches = 0; m_timeouts = 0; m_dropped = 0;
  endfunction

  function bit model_en();
    return !m_clear && !m_offer && (m_pend.size() < MAXB);
  endfunction

  function logic [1:0] model_state();
    if (m_clear)                return 2'd3;
    else if (m_offer)           return 2'd2;
    else if (m_pend.size() > 0) return 2'd1;
    else                        return 2'd0;
  endfunction

  // One clock edge of the model given the inputs presented before the edge
  function void model_step(bit acc, logic [63:0] pid, bit fl, bit rdy);
    bit   en;
    bit   was_open;
    bit   full;
    bit   tmo;
    exp_t e;
    en   = model_en();
    m_bc = 0;
    if (acc && !en) m_dropped++;
    if (m_clear) begin
      m_clear = 0;
      m_id++;
    end else if (m_offer) begin
      if (rdy) begin
        m_offer = 0;
        m_clear = 1;
        m_bc    = 1;
        m_batches++;
      end
    end else begin
      was_open = (m_pend.size() > 0);
      if (acc && en) m_pend.push_back(pid);
      if (was_open) begin
        full = (m_pend.size() == MAXB);
        tmo  = (m_age == TMO - 1);
        if (full || fl || tmo) begin
          e.size   = 8'(m_pend.size());
          e.id     = m_id;
          e.pid    = m_pend[0];
          e.reason = full ? 2'b01 : (fl ? 2'b10 : 2'b11);
          if (!full && !fl) m_timeouts++;
          sb.push_back(e);
          m_pend.delete();
          m_offer = 1;
          m_age   = 0;
        end else begin
          m_age++;
        end
      end else if (m_pend.size() > 0) begin
        m_age = 0;
      end
    end
  endfunction

  function void check_all();
    chk("state", 64'(state_o), 64'(model_state()));
    chk("accept_enable", 64'(accept_enable), 64'(model_en()));
    chk("batch_valid", 64'(batch_valid), 64'(m_offer));
    chk("batch_completed", 64'(batch_completed), 64'(m_bc));
    chk("batch_id_reg", 64'(batch_id), 64'(m_id));
    chk("stat_batches", 64'(stat_batches), 64'(m_batches));
    chk("stat_timeouts", 64'(stat_timeouts), 64'(m_timeouts));
    chk("stat_dropped", 64'(stat_dropped), 64'(m_dropped));
  endfunction

  function void check_reset_fields();
    chk("rst_batch_size", 64'(batch_size), 64'd0);
    chk("rst_first_pid", batch_first_pid, 64'd0);
    chk("rst_reason", 64'(batch_reason), 64'd0);
  endfunction

  // Monitor: compare the offered batch against the scoreboard head every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && batch_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_batch: got batch_valid=1 expected no batch (t=%0t)", $time);
        end else begin
          chk("batch_size", 64'(batch_size), 64'(sb[0].size));
          chk("batch_id", 64'(batch_id), 64'(sb[0].id));
          chk("batch_first_pid", batch_first_pid, sb[0].pid);
          chk("batch_reason", 64'(batch_reason), 64'(sb[0].reason));
          if (batch_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Stimulus: randomized traffic in phases, with occasional mid-batch resets
  initial begin
    bit          p_acc;
    bit          p_fl;
    bit          p_rdy;
    logic [63:0] p_pid;
    int          mode;
    int          pa;
    int          pf;
    int          pr;
    int          resets;
    rst_n = 1'b0; txn_accept = 1'b0; txn_programID = '0;
    flush_req = 1'b0; batch_ready = 1'b0;
    p_acc = 0; p_fl = 0; p_rdy = 0; p_pid = '0;
    mode = 0; pa = 50; pf = 10; pr = 70; resets = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check_reset_fields();
    rst_n = 1'b1;
    #1;
    chk("accept_enable_after_reset", 64'(accept_enable), 64'd1);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_n) model_step(p_acc, p_pid, p_fl, p_rdy);
      check_all();
      if (!rst_n) begin
        rst_n = 1'b1;
        #1;
        chk("accept_enable_after_reset", 64'(accept_enable), 64'd1);
      end else if (resets < 3 && cyc > 100 * (resets + 1) && m_pend.size() == 2) begin
        rst_n = 1'b0;
        txn_accept = 1'b0; flush_req = 1'b0; batch_ready = 1'b0;
        p_acc = 0; p_fl = 0; p_rdy = 0;
        model_reset();
        resets++;
        #1;
        check_all();
        check_reset_fields();
        continue;
      end
      if (cyc % 150 == 0) begin
        mode = int'($urandom_range(0, 3));
        case (mode)
          0:       begin pa = 50; pf = 10; pr = 70; end
          1:       begin pa = 5;  pf = 0;  pr = 90; end
          2:       begin pa = 90; pf = 5;  pr = 15; end
          default: begin pa = 40; pf = 40; pr = 80; end
        endcase
      end
      p_acc = ($urandom_range(0, 99) < pa);
      p_fl  = ($urandom_range(0, 99) < pf);
      p_rdy = ($urandom_range(0, 99) < pr);
      p_pid = {$urandom, $urandom};
      txn_accept    = p_acc;
      flush_req     = p_fl;
      batch_ready   = p_rdy;
      txn_programID = p_pid;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
